// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state type and flag-bundle bit positions
// for the registered ALU (alu_seq) and its combinational core.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {IDLE, BUSY} state_e;

  // Bit positions inside the registered flag bundle.
  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_W     = 4;

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: combinational single-cycle datapath (everything except MUL).
// Ports:
//   a, b        WIDTH-bit operands
//   alucontrol  3-bit opcode (alu_pkg OP_*)
//   result      WIDTH-bit result (0 for MUL, which is handled by the sequencer)
//   carry       adder carry-out for ADD/SUB, else 0
//   overflow    signed overflow for ADD/SUB, else 0
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic             sub;
  logic [WIDTH-1:0] b_add;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  // SUB, SLT and SLTU all share the adder in subtract mode.
  assign sub   = (alucontrol == OP_SUB) || (alucontrol == OP_SLT) ||
                 (alucontrol == OP_SLTU);
  assign b_add = b ^ {WIDTH{sub}};
  assign {c_out, sum} = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, sub};
  assign ovf   = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (alucontrol)
      OP_ADD, OP_SUB: begin
        result   = sum;
        carry    = c_out;
        overflow = ovf;
      end
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      // Signed less-than: sign of the difference corrected by overflow.
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      // Unsigned less-than: a borrow occurred (no carry-out).
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, ~c_out};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready on both sides, status flags and a
// WIDTH-cycle shift-add multiplier.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (a, b, alucontrol)
//   out_valid / out_ready output handshake (result, zero, negative, carry, overflow)
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic [FLG_W-1:0]   flags_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   core_res;
  logic               core_c;
  logic               core_v;
  logic [WIDTH-1:0]   acc_d;
  logic               accept;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .result     (core_res),
    .carry      (core_c),
    .overflow   (core_v)
  );

  // A held result blocks new work; a result leaving this cycle does not.
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Accumulator value after this BUSY step; also the final product on the last step.
  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (alucontrol == OP_MUL) begin
              mcand_q     <= a;
              mplier_q    <= b;
              acc_q       <= '0;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              state_q     <= BUSY;
            end else begin
              result_q           <= core_res;
              flags_q[FLG_ZERO]  <= (core_res == '0);
              flags_q[FLG_NEG]   <= core_res[WIDTH-1];
              flags_q[FLG_CARRY] <= core_c;
              flags_q[FLG_OVF]   <= core_v;
              out_valid_q        <= 1'b1;
            end
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_q           <= acc_d;
            flags_q[FLG_ZERO]  <= (acc_d == '0);
            flags_q[FLG_NEG]   <= acc_d[WIDTH-1];
            flags_q[FLG_CARRY] <= 1'b0;
            flags_q[FLG_OVF]   <= 1'b0;
            out_valid_q        <= 1'b1;
            state_q            <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q[FLG_ZERO];
  assign negative  = flags_q[FLG_NEG];
  assign carry     = flags_q[FLG_CARRY];
  assign overflow  = flags_q[FLG_OVF];

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Adds configurable operand width, a valid/ready handshake on both sides, status flags, OR/SLTU operations and a multi-cycle shift-add multiplier.
- Sits between the register-file read stage and writeback in the datapath.
- Single-cycle ops have 1-cycle latency. MUL iterates for WIDTH cycles under a small FSM.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alucontrol  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR, 101 SLT, 110 SLTU, 111 MUL
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result this cycle
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]
- carry  output  1  ADD: carry-out; SUB: carry-out of a + ~b + 1 (1 = no borrow); else 0
- overflow  output  1  signed overflow for ADD/SUB; else 0

Behaviour:
- Reset: state=IDLE, out_valid=0, result=0, all flags=0, iteration counter=0, multiplier registers=0.
- Reset applies in any state, including mid-MUL; the partial product is discarded.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Transfer out occurs when out_valid && out_ready.
  - While out_valid && !out_ready, result and all flags are held stable and in_ready=0.
- Single-cycle ops (000..110):
  - The accepting edge loads result/flags and sets out_valid=1, so the result is visible the cycle after accept.
  - Back-to-back ops at full rate are allowed when out_ready=1 (accept and transfer in the same cycle).
- ADD/SUB:
  - Both ops use one WIDTH-bit adder: sum = a + (b ^ {WIDTH{sub}}) + sub.
  - overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the adder's B input.
- SLT: result = zero-extended (sum[MSB] ^ overflow) of a - b.
- SLTU: result = zero-extended (!carry) of a - b.
- For SLT and SLTU the reported carry/overflow flags are 0; zero and negative are computed on the final result.
- MUL FSM, states IDLE and BUSY:
  - Accept in IDLE latches a into the multiplicand and b into the multiplier, clears the accumulator and counter, sets out_valid=0, then moves to BUSY.
  - Each BUSY cycle: if multiplier[0], add the multiplicand to the accumulator (mod 2^WIDTH); then shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter.
  - When counter == WIDTH-1 on that edge: result = accumulator (low WIDTH bits of the product), flags updated, out_valid=1, next state IDLE.
  - Accept in cycle N gives out_valid=1 in cycle N+WIDTH+1.
  - MUL: carry=overflow=0; the upper product bits are dropped.
  - in_ready=0 throughout BUSY; in_valid is ignored there.
- Counter width is $clog2(WIDTH)+1 bits; it never wraps during an operation.
- Simultaneous accept and transfer in IDLE: the old result leaves and the new op is accepted on the same edge; no cycle is lost.
- Opcodes are all defined; there is no illegal-op path.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_MUL, 3 bits);
  - state enum {IDLE, BUSY};
  - the flag-bundle bit positions.
- Sub-module alu_comb_core(WIDTH) is the combinational single-cycle datapath. It has inputs a, b, alucontrol and outputs result, carry, overflow.
- alu_seq instantiates alu_comb_core and owns the registers, FSM, multiplier and handshake.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, negative=1, carry=0, zero=0, out_valid one cycle after accept.
- SUB 5 - 5 -> result 0, zero=1, carry=1, overflow=0. Then SLT 0xFFFFFFFF vs 1 -> 1, and SLTU 0xFFFFFFFF vs 1 -> 0, both issued back-to-back with out_ready=1 -> three results on three consecutive cycles.
- MUL 0x0000FFFF * 0x00010001 -> 0xFFFFFFFF with out_valid in cycle N+33. in_ready=0 for cycles N+1..N+33; a second in_valid held during BUSY is accepted only after the result transfers.
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles -> result 7 and flags stable, in_ready=0 throughout; out_ready=1 -> transfer, in_ready=1 the next cycle.
- Reset asserted 10 cycles into MUL 0x12345678*3 -> next cycle state IDLE, out_valid=0, result=0, in_ready=1; a new ADD 1+1 gives 2.
- WIDTH=8 instance: MUL 0x10*0x10 -> 0x00 (truncated), zero=1; ADD 0xFF+0x01 -> 0x00, carry=1, zero=1.
